// File: rtl/interface_hcsr04.sv
// -----------------------------------------------------------------------------
// interface_hcsr04
//
// Upstream stage of the sonar datapath. On a start request it fires the
// HC-SR04 trigger pulse, times the width of the returned echo pulse and
// converts that width to a distance in whole centimetres, presented as three
// BCD digits {hundreds, tens, units}. The result is held on medida_o and
// announced with a single-cycle pronto_o pulse.
//
// Build option:
//   HCSR04_TIMEOUT_EN  when defined, a watchdog bounds the time spent waiting
//                      for and measuring the echo. On expiry the block reports
//                      12'h999 together with timeout_o and pronto_o. When
//                      undefined, the FSM waits for echo edges indefinitely
//                      and timeout_o is constant 0.
//
// Parameters:
//   TRIGGER_CYCLES  trigger high time in clocks
//   CM_DIV          echo-high clocks per centimetre
//   TIMEOUT_CYCLES  watchdog limit in clocks (HCSR04_TIMEOUT_EN only)
//
// Ports:
//   clock_i      system clock, all logic on the rising edge
//   reset_i      synchronous active-high reset
//   medir_i      start request, honoured only in IDLE
//   echo_i       asynchronous sensor echo (synchronised internally)
//   trigger_o    sensor trigger pulse (registered)
//   medida_o     distance in BCD cm, updated only when a result is produced
//   pronto_o     one-cycle pulse, medida_o is valid in the same cycle
//   timeout_o    one-cycle pulse on watchdog expiry
//   db_estado_o  current FSM state code
// -----------------------------------------------------------------------------
module interface_hcsr04 #(
  parameter int TRIGGER_CYCLES = 500,
  parameter int CM_DIV         = 2941,
  parameter int TIMEOUT_CYCLES = 1_500_000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        medir_i,
  input  logic        echo_i,
  output logic        trigger_o,
  output logic [11:0] medida_o,
  output logic        pronto_o,
  output logic        timeout_o,
  output logic [3:0]  db_estado_o
);

  // ---------------------------------------------------------------------------
  // Local sizing
  // ---------------------------------------------------------------------------
  localparam int SYNC_STAGES = 2;
  localparam int TRIG_W      = (TRIGGER_CYCLES > 1) ? $clog2(TRIGGER_CYCLES + 1) : 1;
  localparam int CYC_W       = (CM_DIV > 1) ? $clog2(CM_DIV + 1) : 1;

  localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIGGER_CYCLES - 1);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(CM_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'h0,
    S_PREP      = 4'h1,
    S_TRIG      = 4'h2,
    S_WAIT_ECHO = 4'h3,
    S_MEASURE   = 4'h4,
    S_STORE     = 4'h5,
    S_DONE      = 4'h6,
    S_TOUT      = 4'hF
  } state_e;

  state_e state_q, state_d;

  // ---------------------------------------------------------------------------
  // Echo synchroniser: echo_sync lags echo_i by SYNC_STAGES clocks.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] echo_sync_q;
  logic                   echo_sync;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      echo_sync_q <= '0;
    end else begin
      echo_sync_q <= {echo_sync_q[SYNC_STAGES-2:0], echo_i};
    end
  end

  assign echo_sync = echo_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  logic [TRIG_W-1:0] trig_cnt_q, trig_cnt_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [11:0]       bcd_q, bcd_d;
  logic [11:0]       medida_q, medida_d;
  logic              trigger_q, trigger_d;
  logic              wd_expired;

  // ---------------------------------------------------------------------------
  // BCD increment: each digit rolls 9->0 and carries into the next one.
  // When all three digits are 9 the carry leaves the top digit and the
  // counter holds at 999 instead of wrapping to 000.
  // ---------------------------------------------------------------------------
  logic [3:0]  bcd_carry;
  logic [11:0] bcd_inc_raw;
  logic [11:0] bcd_inc;

  assign bcd_carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_bcd
      logic [3:0] dig;
      assign dig               = bcd_q[4*gi +: 4];
      assign bcd_carry[gi+1]   = bcd_carry[gi] & (dig == 4'd9);
      assign bcd_inc_raw[4*gi +: 4] = !bcd_carry[gi] ? dig :
                                      (dig == 4'd9)  ? 4'd0 : dig + 4'd1;
    end
  endgenerate

  assign bcd_inc = bcd_carry[3] ? bcd_q : bcd_inc_raw;

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef HCSR04_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_active;

  // Counts every cycle spent in WAIT_ECHO or MEASURE; restarted in PREP.
  assign wd_active  = (state_q == S_WAIT_ECHO) || (state_q == S_MEASURE);
  assign wd_expired = wd_active && (wd_q == WD_LAST);

  always_comb begin
    wd_d = wd_q;
    if (state_q == S_PREP) begin
      wd_d = '0;
    end else if (wd_active) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  // No watchdog in this build: TOUT is never entered.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wd_expired         = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (medir_i) state_d = S_PREP;
      S_PREP:      state_d = S_TRIG;
      S_TRIG:      if (trig_cnt_q == TRIG_LAST) state_d = S_WAIT_ECHO;
      S_WAIT_ECHO: begin
        if (wd_expired)     state_d = S_TOUT;
        else if (echo_sync) state_d = S_MEASURE;
      end
      S_MEASURE: begin
        if (wd_expired)      state_d = S_TOUT;
        else if (!echo_sync) state_d = S_STORE;
      end
      S_STORE:     state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      S_TOUT:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    pronto_o = (state_q == S_DONE) || (state_q == S_TOUT);
`ifdef HCSR04_TIMEOUT_EN
    timeout_o = (state_q == S_TOUT);
`else
    timeout_o = 1'b0;
`endif
  end

  assign trigger_o   = trigger_q;
  assign medida_o    = medida_q;
  assign db_estado_o = state_q;

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    trig_cnt_d = trig_cnt_q;
    cyc_d      = cyc_q;
    bcd_d      = bcd_q;
    medida_d   = medida_q;
    // Trigger is registered from the next state so it rises together with
    // the first TRIG cycle and lasts exactly as long as TRIG does.
    trigger_d  = (state_d == S_TRIG);

    unique case (state_q)
      S_PREP: begin
        trig_cnt_d = '0;
        cyc_d      = '0;
        bcd_d      = '0;
      end
      S_TRIG: begin
        trig_cnt_d = trig_cnt_q + TRIG_W'(1);
      end
      // The first echo-high cycle is seen in WAIT_ECHO, so it is counted there
      // as well; otherwise every measurement would come out one cycle short.
      S_WAIT_ECHO, S_MEASURE: begin
        if (echo_sync) begin
          if (cyc_q == CYC_LAST) begin
            cyc_d = '0;
            bcd_d = bcd_inc;
          end else begin
            cyc_d = cyc_q + CYC_W'(1);
          end
        end
      end
      S_STORE: begin
        medida_d = bcd_q;
      end
      default: begin
      end
    endcase

    // The timeout result is loaded on entry to TOUT so that it is already on
    // medida_o during the cycle in which pronto_o/timeout_o are high.
    if (state_d == S_TOUT) begin
      medida_d = 12'h999;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      trig_cnt_q <= '0;
      cyc_q      <= '0;
      bcd_q      <= '0;
      medida_q   <= '0;
      trigger_q  <= 1'b0;
    end else begin
      trig_cnt_q <= trig_cnt_d;
      cyc_q      <= cyc_d;
      bcd_q      <= bcd_d;
      medida_q   <= medida_d;
      trigger_q  <= trigger_d;
    end
  end

endmodule

// File: tb/tb_interface_hcsr04.sv
// -----------------------------------------------------------------------------
// tb_interface_hcsr04
//
// Self-checking bench for interface_hcsr04 with TRIGGER_CYCLES=5, CM_DIV=10,
// TIMEOUT_CYCLES=300. Expected distances come from floor(width / CM_DIV),
// clamped to 999 and split into decimal digits.
// -----------------------------------------------------------------------------
module tb_interface_hcsr04;

  localparam int TRIG = 5;
  localparam int DIV  = 10;
  localparam int TMO  = 300;

`ifdef HCSR04_TIMEOUT_EN
  localparam int HMAX = 250;
`else
  localparam int HMAX = 1200;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        medir;
  logic        echo;
  logic        trigger;
  logic [11:0] medida;
  logic        pronto;
  logic        timeout;
  logic [3:0]  db_estado;

  interface_hcsr04 #(
    .TRIGGER_CYCLES (TRIG),
    .CM_DIV         (DIV),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock_i     (clk),
    .reset_i     (reset),
    .medir_i     (medir),
    .echo_i      (echo),
    .trigger_o   (trigger),
    .medida_o    (medida),
    .pronto_o    (pronto),
    .timeout_o   (timeout),
    .db_estado_o (db_estado)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int          pronto_seen;
  int          trig_seen;
  int          timeout_seen_total = 0;
  logic [11:0] pronto_medida;
  logic        pronto_tmo;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference distance: whole centimetres, truncated, clamped at 999, in BCD.
  function automatic logic [11:0] ref_bcd(input int h);
    int d;
    d = h / DIV;
    if (d > 999) d = 999;
    return {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
  endfunction

  // One clock: outputs are sampled on the falling edge, inputs change here too.
  task automatic tick();
    @(negedge clk);
    if (pronto) begin
      pronto_seen++;
      pronto_medida = medida;
      pronto_tmo    = timeout;
    end
    if (trigger) trig_seen++;
    if (timeout) timeout_seen_total++;
  endtask

  // Pulse medir and verify the trigger pulse (start at N+2, exact width).
  task automatic start_and_trigger(input string tag);
    int n;
    medir = 1'b1;
    tick();
    check({tag, "_trig_n1"}, 32'(trigger), 32'd0);
    medir = 1'b0;
    tick();
    check({tag, "_trig_n2"}, 32'(trigger), 32'd1);
    n = 0;
    while (trigger && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_trig_len"}, 32'(trig_seen), 32'(TRIG));
  endtask

  // Wait for pronto with a bound; returns the number of ticks taken.
  task automatic wait_pronto(input int limit, output int lat);
    lat = 0;
    while (pronto_seen == 0 && lat < limit) begin
      tick();
      lat++;
    end
  endtask

  task automatic measure(input int h, input string tag);
    int lat;
    logic [11:0] exp;
    exp         = ref_bcd(h);
    pronto_seen = 0;
    trig_seen   = 0;
    start_and_trigger(tag);
    repeat ($urandom_range(0, 4)) tick();
    echo = 1'b1;
    repeat (h) tick();
    echo = 1'b0;
    wait_pronto(30, lat);
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_medida_at_pronto"}, 32'(pronto_medida), 32'(exp));
    repeat (6) tick();
    check({tag, "_pronto_count"}, 32'(pronto_seen), 32'd1);
    check({tag, "_medida_held"}, 32'(medida), 32'(exp));
    check({tag, "_state_idle"}, 32'(db_estado), 32'd0);
    $display("measure %s: echo=%0d cycles medida=%03h expected=%03h", tag, h, medida, exp);
  endtask

  int fixed_h[8];

  initial begin
    int lat;
    int h;

    reset = 1'b1;
    medir = 1'b0;
    echo  = 1'b0;
    pronto_seen = 0;
    trig_seen   = 0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state and quiet idle.
    pronto_seen = 0;
    trig_seen   = 0;
    repeat (20) tick();
    check("idle_trigger", 32'(trigger), 32'd0);
    check("idle_pronto",  32'(pronto), 32'd0);
    check("idle_medida",  32'(medida), 32'd0);
    check("idle_state",   32'(db_estado), 32'd0);
    check("idle_no_trig", 32'(trig_seen), 32'd0);
    check("idle_no_pronto", 32'(pronto_seen), 32'd0);
    $display("idle: trigger=%0d pronto=%0d medida=%03h state=%0h", trigger, pronto, medida, db_estado);

    // Directed widths, including the cm boundaries and saturation.
`ifdef HCSR04_TIMEOUT_EN
    fixed_h = '{123, 10, 9, 1, 19, 20, 99, 100};
`else
    fixed_h = '{123, 10, 9, 12000, 9990, 1, 19, 20};
`endif
    foreach (fixed_h[i]) measure(fixed_h[i], $sformatf("fixed%0d", i));

    // Randomised widths.
    for (int i = 0; i < 8; i++) begin
      h = $urandom_range(1, HMAX);
      measure(h, $sformatf("rand%0d", i));
    end

    // medir during MEASURE must be ignored: one trigger, one pronto, width 41.
    pronto_seen = 0;
    trig_seen   = 0;
    start_and_trigger("ignore");
    echo = 1'b1;
    repeat (20) tick();
    medir = 1'b1;
    tick();
    medir = 1'b0;
    repeat (20) tick();
    echo = 1'b0;
    wait_pronto(30, lat);
    check("ignore_medida", 32'(pronto_medida), 32'(ref_bcd(41)));
    repeat (10) tick();
    check("ignore_trig_count", 32'(trig_seen), 32'(TRIG));
    check("ignore_pronto_count", 32'(pronto_seen), 32'd1);
    check("ignore_state", 32'(db_estado), 32'd0);
    $display("ignore: medida=%03h triggers=%0d prontos=%0d", pronto_medida, trig_seen, pronto_seen);

    // Reset in the middle of MEASURE aborts without a result.
    pronto_seen = 0;
    trig_seen   = 0;
    start_and_trigger("abort");
    echo = 1'b1;
    repeat (30) tick();
    check("abort_in_measure", 32'(db_estado), 32'd4);
    reset = 1'b1;
    tick();
    check("abort_trigger", 32'(trigger), 32'd0);
    check("abort_state",   32'(db_estado), 32'd0);
    check("abort_medida",  32'(medida), 32'd0);
    check("abort_pronto",  32'(pronto), 32'd0);
    reset = 1'b0;
    echo  = 1'b0;
    repeat (10) tick();
    check("abort_no_pronto", 32'(pronto_seen), 32'd0);
    $display("abort: state=%0h medida=%03h prontos=%0d", db_estado, medida, pronto_seen);
    measure(50, "after_abort");

`ifdef HCSR04_TIMEOUT_EN
    // Echo never rises: TOUT after TIMEOUT_CYCLES in WAIT_ECHO.
    pronto_seen = 0;
    trig_seen   = 0;
    medir = 1'b1;
    tick();
    medir = 1'b0;
    lat = 1;
    while (pronto_seen == 0 && lat < 2 + TRIG + TMO + 50) begin
      tick();
      lat++;
    end
    check("tout_latency", 32'(lat), 32'(2 + TRIG + TMO));
    check("tout_flag",    32'(pronto_tmo), 32'd1);
    check("tout_medida",  32'(pronto_medida), 32'h999);
    repeat (4) tick();
    check("tout_pronto_count", 32'(pronto_seen), 32'd1);
    check("tout_state", 32'(db_estado), 32'd0);
    $display("timeout: cycles=%0d timeout=%0d medida=%03h", lat, pronto_tmo, pronto_medida);
`else
    check("no_timeout_pulses", 32'(timeout_seen_total), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
